// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF->ID skid stage.
package if_id_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int PC_W_DEF    = 32;
  localparam int SB_W_DEF    = 1;

  // Instruction value shown while the stage holds nothing.
  localparam logic [INSTR_W_DEF-1:0] NOP_DEF = {INSTR_W_DEF{1'b0}};

  // The encoding matches the number of entries held.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Payload carried from fetch to decode, at the default widths.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
    logic [SB_W_DEF-1:0]    sb;
  } payload_t;

  // Number of valid entries for a given state.
  function automatic logic [1:0] occOf(input state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ONE:     n = 2'd1;
      FULL:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/if_id_skid_stage_payload_reg.sv
// Payload register with load, clear-to-idle-value and asynchronous reset.
// Clear wins over load so a flush can never leave a stale entry behind.
module pipe_payload_reg #(
  parameter int           W       = 65,
  parameter logic [W-1:0] CLR_VAL = {W{1'b0}}
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Hold the payload; reset or clear returns it to the idle value.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_q <= CLR_VAL;
    end else if (i_clear) begin
      r_q <= CLR_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF->ID pipeline register with valid/ready handshake, optional two-entry
// skid buffer (registered in_ready), flush and back-pressure.
// The main entry always drives the outputs; the skid entry only absorbs the
// one extra word IF may push while in_ready is still high from last cycle.
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int                 INSTR_W = INSTR_W_DEF,
  parameter int                 PC_W    = PC_W_DEF,
  parameter int                 SB_W    = SB_W_DEF,
  parameter int                 SKID    = 1,
  parameter logic [INSTR_W-1:0] NOP     = {INSTR_W{1'b0}}
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic [PC_W-1:0]    pc_in,
  input  logic [SB_W-1:0]    sb_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instruction_out,
  output logic [PC_W-1:0]    pc_out,
  output logic [SB_W-1:0]    sb_out,
  output logic [1:0]         occupancy
);

  localparam int PW = INSTR_W + PC_W + SB_W;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [SB_W-1:0]    sb;
  } entry_t;

  localparam logic [PW-1:0] CLR_BITS = {NOP, {PC_W{1'b0}}, {SB_W{1'b0}}};

  state_t r_state;
  state_t w_nextState;
  logic   w_inXfer;
  logic   w_outXfer;
  logic   w_mainLoad;
  logic   w_mainClear;
  logic   w_mainFromSkid;
  logic   w_skidLoad;
  logic   w_skidClear;
  entry_t w_inEntry;
  entry_t w_mainD;
  entry_t w_mainQ;
  entry_t w_skidQ;

  assign w_inEntry = '{instr: instruction_in, pc: pc_in, sb: sb_in};
  assign out_valid = (r_state != EMPTY);
  assign w_inXfer  = in_valid & in_ready;
  assign w_outXfer = out_valid & out_ready;
  assign w_mainD   = w_mainFromSkid ? w_skidQ : w_inEntry;

  // Next state and register load/clear selection; flush overrides everything.
  always_comb begin
    w_nextState    = r_state;
    w_mainLoad     = 1'b0;
    w_mainClear    = 1'b0;
    w_mainFromSkid = 1'b0;
    w_skidLoad     = 1'b0;
    w_skidClear    = 1'b0;
    if (flush) begin
      w_nextState = EMPTY;
      w_mainClear = 1'b1;
      w_skidClear = 1'b1;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inXfer) begin
            w_mainLoad  = 1'b1;
            w_nextState = ONE;
          end
        end
        ONE: begin
          if (w_inXfer && w_outXfer) begin
            w_mainLoad = 1'b1;
          end else if (w_outXfer) begin
            w_mainClear = 1'b1;
            w_nextState = EMPTY;
          end else if (w_inXfer && (SKID != 0)) begin
            w_skidLoad  = 1'b1;
            w_nextState = FULL;
          end
        end
        FULL: begin
          if (w_outXfer) begin
            w_mainLoad     = 1'b1;
            w_mainFromSkid = 1'b1;
            w_skidClear    = 1'b1;
            w_nextState    = ONE;
          end
        end
        default: begin
          w_nextState = EMPTY;
          w_mainClear = 1'b1;
          w_skidClear = 1'b1;
        end
      endcase
    end
  end

  // State register; reset drops every held entry at once.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nextState;
    end
  end

  pipe_payload_reg #(
    .W       (PW),
    .CLR_VAL (CLR_BITS)
  ) u_main (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_load  (w_mainLoad),
    .i_clear (w_mainClear),
    .i_d     (w_mainD),
    .o_q     (w_mainQ)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic r_inReady;

      pipe_payload_reg #(
        .W       (PW),
        .CLR_VAL (CLR_BITS)
      ) u_skid (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_load  (w_skidLoad),
        .i_clear (w_skidClear),
        .i_d     (w_inEntry),
        .o_q     (w_skidQ)
      );

      // Registered ready: low only while both entries are occupied.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          r_inReady <= 1'b1;
        end else begin
          r_inReady <= (w_nextState != FULL);
        end
      end

      assign in_ready = r_inReady;
    end else begin : g_noSkid
      assign w_skidQ  = CLR_BITS;
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  assign instruction_out = w_mainQ.instr;
  assign pc_out          = w_mainQ.pc;
  assign sb_out          = w_mainQ.sb;
  assign occupancy       = occOf(r_state);

endmodule
